// File: rtl/bp_pkg.sv
// Shared types and constants for the local branch predictor and its
// Fetch->Decode->Execute metadata tracker.
package bp_pkg;

  localparam int PHT_INDEX_BITS_DEFAULT = 10;
  localparam int BHT_INDEX_BITS_DEFAULT = 3;

  // Fall-through target of a not-taken branch skips the delay slot.
  localparam logic [31:0] DELAY_SLOT_OFFSET = 32'd8;

  // Two-bit saturating counter states of the local predictor's PHT.
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_state_t;

  // Stage metadata at the default index widths; the pipeline stage module
  // rebuilds the same layout from the widths handed to it.
  typedef struct packed {
    logic                              valid;
    logic [31:0]                       pc;
    logic                              pred_taken;
    logic [BHT_INDEX_BITS_DEFAULT-1:0] bht_idx;
    logic [PHT_INDEX_BITS_DEFAULT-1:0] pht_idx;
  } bp_meta_t;

endpackage

// File: rtl/bp_meta_stage.sv
// One pipeline register of branch-prediction metadata; flush beats stall,
// stall holds, otherwise the upstream entry is captured.
module bp_meta_stage
  import bp_pkg::*;
#(
  parameter int PHT_INDEX_BITS = PHT_INDEX_BITS_DEFAULT,
  parameter int BHT_INDEX_BITS = BHT_INDEX_BITS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall,
  input  logic                      nxt_valid,
  input  logic [31:0]               nxt_pc,
  input  logic                      nxt_pred_taken,
  input  logic [BHT_INDEX_BITS-1:0] nxt_bht_idx,
  input  logic [PHT_INDEX_BITS-1:0] nxt_pht_idx,
  output logic                      valid,
  output logic [31:0]               pc,
  output logic                      pred_taken,
  output logic [BHT_INDEX_BITS-1:0] bht_idx,
  output logic [PHT_INDEX_BITS-1:0] pht_idx
);

  typedef struct packed {
    logic                      valid;
    logic [31:0]               pc;
    logic                      pred_taken;
    logic [BHT_INDEX_BITS-1:0] bht_idx;
    logic [PHT_INDEX_BITS-1:0] pht_idx;
  } meta_t;

  meta_t cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= '0;
    end else if (flush) begin
      cur <= '0;
    end else if (!stall) begin
      cur <= '{valid:      nxt_valid,
               pc:         nxt_pc,
               pred_taken: nxt_pred_taken,
               bht_idx:    nxt_bht_idx,
               pht_idx:    nxt_pht_idx};
    end
  end

  assign valid      = cur.valid;
  assign pc         = cur.pc;
  assign pred_taken = cur.pred_taken;
  assign bht_idx    = cur.bht_idx;
  assign pht_idx    = cur.pht_idx;

endmodule

// File: rtl/branch_predict_tracker.sv
// Carries predictor metadata from Fetch to Execute, resolves conditional
// branches there, and produces training, redirect and statistics outputs.
module branch_predict_tracker
  import bp_pkg::*;
#(
  parameter int PHT_INDEX_BITS = PHT_INDEX_BITS_DEFAULT,
  parameter int BHT_INDEX_BITS = BHT_INDEX_BITS_DEFAULT,
  parameter int CNT_BITS       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               pcF,
  input  logic                      predict_takeF,
  input  logic [BHT_INDEX_BITS-1:0] pc_hashingF,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      stallD,
  input  logic                      flushD,
  input  logic                      stallE,
  input  logic                      flushE,
  input  logic                      branchE,
  input  logic                      actually_takenE,
  input  logic [31:0]               branch_targetE,
  output logic                      predict_takeD,
  output logic                      upd_validE,
  output logic [BHT_INDEX_BITS-1:0] upd_bht_indexE,
  output logic [PHT_INDEX_BITS-1:0] upd_pht_indexE,
  output logic                      upd_takenE,
  output logic                      mispredictE,
  output logic [31:0]               redirect_pcE,
  output logic [CNT_BITS-1:0]       branch_cnt,
  output logic [CNT_BITS-1:0]       miss_cnt
);

  logic                      validD, validE;
  logic [31:0]               pcD, pcE;
  logic                      pred_takenD, pred_takenE;
  logic [BHT_INDEX_BITS-1:0] bht_idxD, bht_idxE;
  logic [PHT_INDEX_BITS-1:0] pht_idxD, pht_idxE;
  logic                      resolveE;

  bp_meta_stage #(
    .PHT_INDEX_BITS(PHT_INDEX_BITS),
    .BHT_INDEX_BITS(BHT_INDEX_BITS)
  ) u_stage_d (
    .clk           (clk),
    .rst           (rst),
    .flush         (flushD),
    .stall         (stallD),
    .nxt_valid     (1'b1),
    .nxt_pc        (pcF),
    .nxt_pred_taken(predict_takeF),
    .nxt_bht_idx   (pc_hashingF),
    .nxt_pht_idx   (PHT_indexF),
    .valid         (validD),
    .pc            (pcD),
    .pred_taken    (pred_takenD),
    .bht_idx       (bht_idxD),
    .pht_idx       (pht_idxD)
  );

  bp_meta_stage #(
    .PHT_INDEX_BITS(PHT_INDEX_BITS),
    .BHT_INDEX_BITS(BHT_INDEX_BITS)
  ) u_stage_e (
    .clk           (clk),
    .rst           (rst),
    .flush         (flushE),
    .stall         (stallE),
    .nxt_valid     (validD),
    .nxt_pc        (pcD),
    .nxt_pred_taken(pred_takenD),
    .nxt_bht_idx   (bht_idxD),
    .nxt_pht_idx   (pht_idxD),
    .valid         (validE),
    .pc            (pcE),
    .pred_taken    (pred_takenE),
    .bht_idx       (bht_idxE),
    .pht_idx       (pht_idxE)
  );

  assign predict_takeD  = pred_takenD;
  assign resolveE       = validE & branchE;
  assign upd_validE     = resolveE;
  assign upd_bht_indexE = bht_idxE;
  assign upd_pht_indexE = pht_idxE;
  assign upd_takenE     = actually_takenE;
  assign mispredictE    = resolveE & (pred_takenE ^ actually_takenE);

  // A bubble in Execute drives a zero redirect rather than a stale target.
  always_comb begin
    redirect_pcE = '0;
    if (validE) begin
      redirect_pcE = actually_takenE ? branch_targetE : pcE + DELAY_SLOT_OFFSET;
    end
  end

  // Counting only on non-stalled edges makes a held branch count once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else if (!stallE) begin
      if (resolveE && (branch_cnt != '1)) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if (mispredictE && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

endmodule
